uart_rx_bit_controller: RTL and testbench

Receive-side front end of the UART RX path. Oversamples the synchronised serial line, majority-votes each bit and runs the frame state machine (start, data, parity, stop). It drives the downstream 8-bit deserializer with a registered `SampledBit`, one `DeserEnable` pulse per data bit and one `DeserLoad` pulse per accepted frame. It also reports frame status to the RX top level.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_data_sampler.sv | 66 ++++++
 rtl/uart_rx_bit_controller.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_bit_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive path:
//   - rx_state_e       : frame state machine encoding
//   - PRESCALE_DEFAULT : oversampling ratio used for unsupported Prescale values
//   - PAR_EVEN/PAR_ODD : encodings of the PAR_TYP input
//   - maj3()           : two-out-of-three majority vote
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int PRESCALE_DEFAULT = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_data_sampler
// Takes three samples of the serial line around the middle of each bit period
// (edge_cnt = P/2-1, P/2, P/2+1) and registers their majority vote.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   rx_in        synchronised serial line
//   sample_en    high while a frame is being received
//   edge_cnt     position inside the current bit period (0..P-1)
//   prescale     latched oversampling ratio P
//   sampled_bit  registered vote, valid from edge_cnt = P/2+2 onwards
// -----------------------------------------------------------------------------
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  sample_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit
);

    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] half_m1;
    logic [PRESCALE_W-1:0] half_p1;

    logic samp0_q, samp0_d;
    logic samp1_q, samp1_d;
    logic bit_q,   bit_d;

    assign half    = prescale >> 1;
    assign half_m1 = half - PRESCALE_W'(1);
    assign half_p1 = half + PRESCALE_W'(1);

    // The third sample is not stored: it is voted directly from the line.
    always_comb begin
        samp0_d = samp0_q;
        samp1_d = samp1_q;
        bit_d   = bit_q;
        if (sample_en) begin
            if (edge_cnt == half_m1) samp0_d = rx_in;
            if (edge_cnt == half)    samp1_d = rx_in;
            if (edge_cnt == half_p1) bit_d   = maj3(samp0_q, samp1_q, rx_in);
        end
    end

    // Samples reset to the idle line level so a fresh vote is never biased low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
            bit_q   <= 1'b1;
        end else begin
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
            bit_q   <= bit_d;
        end
    end

    assign sampled_bit = bit_q;

endmodule

// File: rtl/uart_rx_bit_controller.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_controller
// Frame state machine of the UART receiver: start / data / parity / stop,
// with bit-period and data-bit counters. Feeds an external 8-bit deserializer.
// Ports:
//   CLK, RST      oversampling clock, asynchronous active-low reset
//   RX_IN         synchronised serial line (idle high)
//   Prescale      oversampling ratio (8, 16, 32; anything else runs as 8)
//   PAR_EN        parity bit present
//   PAR_TYP       0 = even, 1 = odd
//   SampledBit    registered majority-vote bit
//   DeserEnable   shift strobe, one per data bit
//   DeserLoad     parallel-load strobe, one per accepted frame
//   DataValid     frame accepted pulse
//   ParityError   parity mismatch pulse (valid stop bit)
//   FramingError  stop bit sampled low pulse
//   Busy          frame in progress
// -----------------------------------------------------------------------------
module uart_rx_bit_controller
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  SampledBit,
    output logic                  DeserEnable,
    output logic                  DeserLoad,
    output logic                  DataValid,
    output logic                  ParityError,
    output logic                  FramingError,
    output logic                  Busy
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rx_state_e state_q, state_d;

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_typ_q,  par_typ_d;
    logic                  xor_q,      xor_d;
    logic                  par_bad_q,  par_bad_d;

    logic [PRESCALE_W-1:0] half;
    logic                  vote_pt;
    logic                  last_edge;
    logic                  prescale_ok;
    logic                  exp_par;
    logic                  sampled_bit;

    assign half        = prescale_q >> 1;
    assign vote_pt     = (edge_cnt_q == half + PRESCALE_W'(2));
    assign last_edge   = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
    assign prescale_ok = (Prescale == PRESCALE_W'(8))  ||
                         (Prescale == PRESCALE_W'(16)) ||
                         (Prescale == PRESCALE_W'(32));
    assign exp_par     = (par_typ_q == PAR_EVEN) ? xor_q : ~xor_q;

    uart_rx_data_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .rx_in       (RX_IN),
        .sample_en   (state_q != ST_IDLE),
        .edge_cnt    (edge_cnt_q),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit)
    );

    assign SampledBit = sampled_bit;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!RX_IN) state_d = ST_START;
            end
            ST_START: begin
                // A start bit that votes high was a line glitch.
                if (vote_pt && sampled_bit) state_d = ST_IDLE;
                else if (last_edge)         state_d = ST_DATA;
            end
            ST_DATA: begin
                if (last_edge && (bit_cnt_q == LAST_BIT))
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (last_edge) state_d = ST_STOP;
            end
            ST_STOP: begin
                // Leave mid-stop-bit so an immediately following start bit
                // is seen from its very first low cycle.
                if (vote_pt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- counters and frame context ----------------
    always_comb begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
        bit_cnt_d  = bit_cnt_q;
        prescale_d = prescale_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        xor_d      = xor_q;
        par_bad_d  = par_bad_q;

        unique case (state_q)
            ST_IDLE: begin
                // The detect cycle itself is not part of the start bit count.
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    prescale_d = prescale_ok ? Prescale : PRESCALE_W'(PRESCALE_DEFAULT);
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    xor_d      = 1'b0;
                    par_bad_d  = 1'b0;
                end
            end
            ST_START: begin
                if (last_edge) edge_cnt_d = '0;
            end
            ST_DATA: begin
                if (vote_pt) xor_d = xor_q ^ sampled_bit;
                if (last_edge) begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_W'(1);
                end
            end
            ST_PARITY: begin
                if (vote_pt && (sampled_bit != exp_par)) par_bad_d = 1'b1;
                if (last_edge) edge_cnt_d = '0;
            end
            ST_STOP: begin
            end
            default: begin
            end
        endcase

        // Any return to IDLE (glitch or end of frame) restarts the bit timer.
        if (state_d == ST_IDLE) edge_cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            prescale_q <= PRESCALE_W'(PRESCALE_DEFAULT);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            xor_q      <= 1'b0;
            par_bad_q  <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            prescale_q <= prescale_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            xor_q      <= xor_d;
            par_bad_q  <= par_bad_d;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        DeserEnable  = 1'b0;
        DeserLoad    = 1'b0;
        DataValid    = 1'b0;
        ParityError  = 1'b0;
        FramingError = 1'b0;
        Busy         = (state_q != ST_IDLE);
        unique case (state_q)
            ST_DATA: begin
                DeserEnable = vote_pt;
            end
            ST_STOP: begin
                if (vote_pt) begin
                    if (!sampled_bit)   FramingError = 1'b1;
                    else if (par_bad_q) ParityError  = 1'b1;
                    else begin
                        DeserLoad = 1'b1;
                        DataValid = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_bit_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_bit_controller
// Drives serial frames onto RX_IN and checks every strobe the controller emits
// against a queue of expected strobes (kind, cycle, sampled bit).
// -----------------------------------------------------------------------------
module tb_uart_rx_bit_controller;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_in    = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en   = 1'b0;
    logic       par_typ  = 1'b0;

    logic sampled_bit, deser_enable, deser_load, data_valid;
    logic parity_error, framing_error, busy;

    uart_rx_bit_controller #(
        .DATA_BITS  (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_IN        (rx_in),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .SampledBit   (sampled_bit),
        .DeserEnable  (deser_enable),
        .DeserLoad    (deser_load),
        .DataValid    (data_valid),
        .ParityError  (parity_error),
        .FramingError (framing_error),
        .Busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Strobe vector order: {DeserEnable, DeserLoad, DataValid, ParityError, FramingError}
    localparam logic [4:0] V_EN   = 5'b10000;
    localparam logic [4:0] V_LOAD = 5'b01100;
    localparam logic [4:0] V_PERR = 5'b00010;
    localparam logic [4:0] V_FERR = 5'b00001;

    typedef struct {
        logic [4:0] vec;
        logic       bitv;
        int         at;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int         pres;
        logic       pe;
        logic       pt;
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic [4:0] outcome;
        int         gbit;
        int         goff;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tbl[NVEC];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Strobe monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [4:0] v;
        exp_t       e;
        v = {deser_enable, deser_load, data_valid, parity_error, framing_error};
        if (v != 5'b0) begin
            $display("strobe vec=%b bit=%0d cycle=%0d", v, sampled_bit, cyc);
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'(v), 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", int'(v), int'(e.vec));
                check("strobe_cycle", cyc, e.at);
                if (e.vec == V_EN) check("sampled_bit", int'(sampled_bit), int'(e.bitv));
            end
        end
    end

    // Holds one wire bit for p cycles; optionally inverts it for one cycle.
    task automatic drive_bit(input logic b, input int p, input int goff);
        for (int c = 0; c < p; c++) begin
            rx_in = (c == goff) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int eff_p(input int pres);
        return (pres == 8 || pres == 16 || pres == 32) ? pres : 8;
    endfunction

    // Drives a full frame and queues the strobes it must cause.
    task automatic send_frame(input vec_t v);
        int   p;
        int   t0;
        exp_t e;
        p       = eff_p(v.pres);
        prescale = 6'(v.pres);
        par_en  = v.pe;
        par_typ = v.pt;
        t0      = cyc;
        for (int i = 0; i < 8; i++) begin
            e.vec  = V_EN;
            e.bitv = v.data[i];
            e.at   = t0 + 1 + p * (i + 1) + p / 2 + 2;
            sb.push_back(e);
        end
        e.vec  = v.outcome;
        e.bitv = 1'b0;
        e.at   = t0 + 1 + p * (9 + (v.pe ? 1 : 0)) + p / 2 + 2;
        sb.push_back(e);
        $display("frame P=%0d pe=%0d pt=%0d data=%02h pbit=%0d stop=%0d", v.pres, v.pe, v.pt, v.data, v.pbit, v.sbit);
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++) drive_bit(v.data[i], p, (i == v.gbit) ? v.goff : -1);
        if (v.pe) drive_bit(v.pbit, p, -1);
        drive_bit(v.sbit, p, -1);
        rx_in = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_queue_empty"}, sb.size(), 0);
        check({tag, "_busy"}, int'(busy), 0);
        sb.delete();
    endtask

    initial begin
        exp_t e;
        int   t0;

        //          pres pe    pt    data   pbit  sbit  outcome gbit goff
        tbl[0]  = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, V_LOAD, -1, -1};
        tbl[1]  = '{16, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, V_PERR, -1, -1};
        tbl[2]  = '{16, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, V_LOAD, -1, -1};
        tbl[3]  = '{8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, V_FERR, -1, -1};
        tbl[4]  = '{32, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, V_LOAD,  3, 17};
        tbl[5]  = '{16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, V_LOAD, -1, -1};
        tbl[6]  = '{16, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, V_PERR, -1, -1};
        tbl[7]  = '{8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, V_FERR, -1, -1};
        tbl[8]  = '{12, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, V_LOAD, -1, -1};
        tbl[9]  = '{32, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, V_LOAD, -1, -1};
        tbl[10] = '{8,  1'b1, 1'b1, 8'h80, 1'b0, 1'b1, V_LOAD, -1, -1};

        // Reset values while RST is held low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sampled_bit", int'(sampled_bit), 1);
        check("rst_strobes", int'({deser_enable, deser_load, data_valid, parity_error, framing_error}), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        idle(4);

        // Table-driven frames.
        for (int k = 0; k < NVEC; k++) begin
            send_frame(tbl[k]);
            idle(2 * eff_p(tbl[k].pres) + 4);
            check_quiet($sformatf("vec%0d", k));
        end

        // Short low pulse: rejected as a glitch at the start-bit vote.
        $display("glitch start P=16");
        prescale = 6'd16;
        par_en   = 1'b0;
        rx_in    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
        check("glitch_busy_during", int'(busy), 1);
        idle(40);
        check_quiet("glitch");
        check("glitch_sampled_bit", int'(sampled_bit), 1);

        // Back-to-back frames, reset during bit 4 of the second one.
        $display("back-to-back P=8 with reset in frame 2");
        send_frame('{8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, V_LOAD, -1, -1});
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            e.vec  = V_EN;
            e.bitv = 1'b1;
            e.at   = t0 + 1 + 8 * (i + 1) + 6;
            sb.push_back(e);
        end
        drive_bit(1'b0, 8, -1);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8, -1);
        drive_bit(1'b1, 2, -1);
        check("b2b_busy_before_rst", int'(busy), 1);
        check("b2b_queue_before_rst", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_sampled_bit", int'(sampled_bit), 1);
        check("midrst_strobes", int'({deser_enable, deser_load, data_valid, parity_error, framing_error}), 0);
        check("midrst_busy", int'(busy), 0);
        idle(3);
        rst_n = 1'b1;
        idle(30);
        check_quiet("b2b");
        check("b2b_sampled_bit", int'(sampled_bit), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
